// File: rtl/sdpram_bist_pkg.sv
// Shared types and constants for the simple-dual-port RAM BIST controller.
package sdpram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  localparam logic [1:0] PAT_DOWN = 2'd0;
  localparam logic [1:0] PAT_ADDR = 2'd1;
  localparam logic [1:0] PAT_LFSR = 2'd2;
  localparam logic [1:0] PAT_CHK  = 2'd3;

  // Fibonacci taps for x^32+x^22+x^2+x+1 (state bits 31, 21, 1, 0)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sdpram_bist_patgen.sv
// Pattern word generator: one word per address, LFSR restart/advance, optional inversion.
module sdpram_bist_patgen
  import sdpram_bist_pkg::*;
#(
  parameter int          ADDR_W = 9,
  parameter int          DATA_W = 21,
  parameter logic [31:0] SEED   = 32'hACE1
) (
  input  logic              wr_clk,
  input  logic              tb_wr_rst,
  input  logic              restart,
  input  logic              advance,
  input  logic              inv,
  input  logic [1:0]        pattern,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);

  logic [31:0]       lfsr;
  logic [DATA_W-1:0] rep;
  logic [DATA_W-1:0] chk_odd;
  logic [DATA_W-1:0] base;

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst)    lfsr <= SEED;
    else if (restart) lfsr <= SEED;
    else if (advance) lfsr <= lfsr_step(lfsr);
  end

  // LFSR state replicated across wide words; checkerboard with odd bits set
  for (genvar i = 0; i < DATA_W; i++) begin : g_bits
    assign rep[i]     = lfsr[i % 32];
    assign chk_odd[i] = ((i % 2) == 1) ? 1'b1 : 1'b0;
  end

  always_comb begin
    base = '0;
    unique case (pattern)
      PAT_DOWN: base = {DATA_W{1'b1}} - DATA_W'(addr);
      PAT_ADDR: base = DATA_W'(addr);
      PAT_LFSR: base = rep;
      PAT_CHK:  base = addr[0] ? chk_odd : ~chk_odd;
      default:  base = '0;
    endcase
  end

  assign word = base ^ {DATA_W{inv}};

endmodule

// File: rtl/sdpram_bist_ctrl.sv
// BIST traffic generator/checker for a simple-dual-port RAM.
// Optional second inverted-data pass: define SDPRAM_BIST_INV_PASS_EN.
module sdpram_bist_ctrl
  import sdpram_bist_pkg::*;
#(
  parameter int          ADDR_W = 9,
  parameter int          DATA_W = 21,
  parameter int          RD_LAT = 1,
  parameter int          ERR_W  = 8,
  parameter logic [31:0] SEED   = 32'hACE1
) (
  input  logic              wr_clk,
  input  logic              tb_wr_rst,
  input  logic              start,
  input  logic [1:0]        pattern,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  bist_state_t       state, state_nxt;
  logic              accept;
  logic              last_pass;
  logic              inv;
  logic [ADDR_W-1:0] addr_cnt;
  logic [1:0]        aux_cnt;
  logic [1:0]        pat_q;
  logic [DATA_W-1:0] word;

`ifdef SDPRAM_BIST_INV_PASS_EN
  logic pass2;

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst)                                       pass2 <= 1'b0;
    else if (accept)                                     pass2 <= 1'b0;
    else if (state == ST_DRAIN && state_nxt == ST_WRITE) pass2 <= 1'b1;
  end

  assign last_pass = pass2;
  assign inv       = pass2;
`else
  assign last_pass = 1'b1;
  assign inv       = 1'b0;
`endif

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) begin
        state_nxt = ST_WRITE;
        accept    = 1'b1;
      end
      ST_WRITE: if (addr_cnt == '1) state_nxt = ST_GAP;
      ST_GAP:   if (aux_cnt == 2'd1) state_nxt = ST_READ;
      ST_READ:  if (addr_cnt == '1) state_nxt = ST_DRAIN;
      ST_DRAIN: if (aux_cnt == 2'(RD_LAT - 1))
                  state_nxt = last_pass ? ST_DONE : ST_WRITE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Address counter wraps to 0 exactly at the end of each WRITE/READ sweep
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      addr_cnt <= '0;
      aux_cnt  <= '0;
      pat_q    <= PAT_DOWN;
    end else begin
      addr_cnt <= (state == ST_WRITE || state == ST_READ) ? addr_cnt + 1'b1 : '0;
      aux_cnt  <= ((state == ST_GAP || state == ST_DRAIN) && state_nxt == state)
                  ? aux_cnt + 1'b1 : 2'd0;
      if (accept) pat_q <= pattern;
    end
  end

  sdpram_bist_patgen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_patgen (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .restart   (!(state == ST_WRITE || state == ST_READ)),
    .advance   (state == ST_WRITE || state == ST_READ),
    .inv       (inv),
    .pattern   (pat_q),
    .addr      (addr_cnt),
    .word      (word)
  );

  assign ram_wr_en   = (state == ST_WRITE);
  assign ram_wr_addr = ram_wr_en ? addr_cnt : '0;
  assign ram_wr_data = ram_wr_en ? word : '0;
  assign ram_rd_en   = (state == ST_READ);
  assign ram_rd_addr = ram_rd_en ? addr_cnt : '0;
  assign busy        = (state == ST_WRITE) || (state == ST_GAP) ||
                       (state == ST_READ)  || (state == ST_DRAIN);

  // ---- stage p0: expected word registered alongside the RAM read ----
  logic              vld_p0;
  logic [DATA_W-1:0] exp_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              vld_cmp;
  logic [DATA_W-1:0] exp_cmp;
  logic [ADDR_W-1:0] addr_cmp;

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) vld_p0 <= 1'b0;
    else           vld_p0 <= ram_rd_en;
  end

  always_ff @(posedge wr_clk) begin
    exp_p0  <= word;
    addr_p0 <= addr_cnt;
  end

  // ---- stage p1: present only for a RAM with an output register ----
  if (RD_LAT == 2) begin : g_lat2
    logic              vld_p1;
    logic [DATA_W-1:0] exp_p1;
    logic [ADDR_W-1:0] addr_p1;

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) vld_p1 <= 1'b0;
      else           vld_p1 <= vld_p0;
    end

    always_ff @(posedge wr_clk) begin
      exp_p1  <= exp_p0;
      addr_p1 <= addr_p0;
    end

    assign vld_cmp  = vld_p1;
    assign exp_cmp  = exp_p1;
    assign addr_cmp = addr_p1;
  end else begin : g_lat1
    assign vld_cmp  = vld_p0;
    assign exp_cmp  = exp_p0;
    assign addr_cmp = addr_p0;
  end

  // ---- compare stage: read data against delayed expected word ----
  logic mismatch;
  assign mismatch = vld_cmp && (ram_rd_data != exp_cmp);

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (accept) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0) first_err_addr <= addr_cmp;
      end
      if (state == ST_DONE) begin
        done <= 1'b1;
        pass <= (err_cnt == '0);
      end
    end
  end

endmodule
